// File: rtl/atm_pkg.sv
// -----------------------------------------------------------------------------
// atm_pkg
// Shared definitions for the ATM account arbiter:
//   - opcode encodings driven by the terminals (OP_*)
//   - result codes returned with each completion (ST_*)
//   - transaction FSM state encoding (state_t)
// -----------------------------------------------------------------------------
package atm_pkg;

  // Terminal opcodes
  localparam logic [1:0] OP_INQ = 2'b00;
  localparam logic [1:0] OP_DEP = 2'b01;
  localparam logic [1:0] OP_WDR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  // Transaction result codes
  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_INSUF = 2'b01;
  localparam logic [1:0] ST_LIMIT = 2'b10;
  localparam logic [1:0] ST_ERR   = 2'b11;  // bad opcode or deposit overflow

  // Transaction FSM: latch -> check -> update -> respond
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_UPDATE = 2'd2,
    S_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first asserted request at or
// after i_ptr, wrapping modulo N_REQ.
// Ports:
//   i_req    [N_REQ-1:0]  request vector
//   i_ptr    [ID_W-1:0]   index with highest priority this round
//   o_gnt    [N_REQ-1:0]  one-hot winner (all zero when no request)
//   o_id     [ID_W-1:0]   encoded winner index
//   o_valid               at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_id,
  output logic             o_valid
);

  logic [ID_W-1:0] w_idx;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would infer a latch.
    o_gnt   = '0;
    o_id    = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    // Scan N_REQ slots starting at the pointer; the first hit wins.
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = ID_W'((int'(i_ptr) + i) % N_REQ);
      if (!o_valid && i_req[w_idx]) begin
        o_valid      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_id         = w_idx;
      end
    end
  end

endmodule

// File: rtl/atm_account_arbiter.sv
// -----------------------------------------------------------------------------
// atm_account_arbiter
// Shares one account balance between N_REQ ATM terminals. A round-robin
// arbiter picks one requester; the transaction then runs atomically through
// CHECK (insufficient-funds / withdraw-limit / overflow rules), UPDATE
// (balance write on success) and RESP (one-cycle done pulse).
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   day_clear    (ATM_DAILY_LIMIT_EN only) synchronous clear of the daily total
//   req          per-terminal request, held until done
//   op           per-terminal opcode, 2 bits each
//   amount       per-terminal amount, BAL_W bits each
//   gnt          one-hot grant, high from CHECK through RESP
//   done         one-cycle completion pulse to the granted terminal
//   status       result code, valid with done, held between transactions
//   balance_out  balance after the transaction, valid with done
//   busy         high whenever the FSM is not IDLE
//
// Build option: define ATM_DAILY_LIMIT_EN to add the per-day cumulative
// withdraw limit (parameter DAILY_LIMIT, input day_clear).
// -----------------------------------------------------------------------------
module atm_account_arbiter
  import atm_pkg::*;
#(
  parameter int             N_REQ        = 4,
  parameter int             BAL_W        = 32,
  parameter logic [BAL_W-1:0] INIT_BALANCE = 32'h000F4240,
  parameter logic [BAL_W-1:0] MAX_WITHDRAW = 32'd20000
`ifdef ATM_DAILY_LIMIT_EN
  ,
  parameter logic [BAL_W-1:0] DAILY_LIMIT  = 32'd50000
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef ATM_DAILY_LIMIT_EN
  input  logic                   day_clear,
`endif
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [BAL_W*N_REQ-1:0] amount,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [1:0]             status,
  output logic [BAL_W-1:0]       balance_out,
  output logic                   busy
);

  localparam int ID_W = $clog2(N_REQ);

  state_t           r_state;
  state_t           w_next_state;

  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_id;
  logic [1:0]       r_op;
  logic [BAL_W-1:0] r_amount;
  logic [1:0]       r_result;
  logic [BAL_W-1:0] r_balance;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic [1:0]       r_status;
  logic [BAL_W-1:0] r_balance_out;

  logic [N_REQ-1:0] w_arb_gnt;
  logic [ID_W-1:0]  w_arb_id;
  logic             w_arb_valid;

  logic [1:0]       w_op_arr  [N_REQ];
  logic [BAL_W-1:0] w_amt_arr [N_REQ];

  logic [BAL_W:0]   w_dep_sum;
  logic [1:0]       w_check_result;
  logic [BAL_W-1:0] w_new_balance;
  logic [ID_W-1:0]  w_ptr_next;

`ifdef ATM_DAILY_LIMIT_EN
  logic [BAL_W-1:0] r_withdrawn;
  logic [BAL_W:0]   w_daily_sum;
  logic             w_wdr_commit;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .i_req   (req),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_arb_gnt),
    .o_id    (w_arb_id),
    .o_valid (w_arb_valid)
  );

  // Unpack the flat per-terminal buses so the winner can be selected by id.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_op_arr[i]  = op[i*2 +: 2];
      w_amt_arr[i] = amount[i*BAL_W +: BAL_W];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_arb_valid) w_next_state = S_CHECK;
      S_CHECK:  w_next_state = S_UPDATE;
      S_UPDATE: w_next_state = S_RESP;
      S_RESP:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transaction checks on latched values
  // ---------------------------------------------------------------------------
  // One extra bit catches deposit carry-out past BAL_W.
  assign w_dep_sum = {1'b0, r_balance} + {1'b0, r_amount};

`ifdef ATM_DAILY_LIMIT_EN
  assign w_daily_sum = {1'b0, r_withdrawn} + {1'b0, r_amount};
`endif

  always_comb begin
    w_check_result = ST_OK;
    case (r_op)
      OP_INQ: w_check_result = ST_OK;
      OP_DEP: if (w_dep_sum[BAL_W]) w_check_result = ST_ERR;
      OP_WDR: begin
        // Limit tests take precedence over the funds test.
        if (r_amount > MAX_WITHDRAW)                   w_check_result = ST_LIMIT;
`ifdef ATM_DAILY_LIMIT_EN
        else if (w_daily_sum > {1'b0, DAILY_LIMIT})    w_check_result = ST_LIMIT;
`endif
        else if (r_amount > r_balance)                 w_check_result = ST_INSUF;
        else                                           w_check_result = ST_OK;
      end
      default: w_check_result = ST_ERR;  // OP_RSV
    endcase
  end

  // Balance after UPDATE; errors and inquiries leave it untouched.
  always_comb begin
    w_new_balance = r_balance;
    if (r_result == ST_OK) begin
      case (r_op)
        OP_DEP:  w_new_balance = w_dep_sum[BAL_W-1:0];
        OP_WDR:  w_new_balance = r_balance - r_amount;
        default: w_new_balance = r_balance;
      endcase
    end
  end

  assign w_ptr_next = (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + 1'b1;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr      <= '0;
      r_id          <= '0;
      r_op          <= OP_INQ;
      r_amount      <= '0;
      r_result      <= ST_OK;
      r_balance     <= INIT_BALANCE;
      r_gnt         <= '0;
      r_done        <= '0;
      r_status      <= ST_OK;
      r_balance_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Terminal inputs are sampled only here, on the grant edge.
          if (w_arb_valid) begin
            r_id     <= w_arb_id;
            r_op     <= w_op_arr[w_arb_id];
            r_amount <= w_amt_arr[w_arb_id];
            r_gnt    <= w_arb_gnt;
          end
        end
        S_CHECK: r_result <= w_check_result;
        S_UPDATE: begin
          r_balance     <= w_new_balance;
          r_balance_out <= w_new_balance;
          r_status      <= r_result;
          r_done        <= r_gnt;  // grant is one-hot on the winner
        end
        S_RESP: begin
          r_done   <= '0;
          r_gnt    <= '0;
          r_rr_ptr <= w_ptr_next;  // winner drops to lowest priority
        end
        default: ;
      endcase
    end
  end

`ifdef ATM_DAILY_LIMIT_EN
  assign w_wdr_commit = (r_state == S_UPDATE) && (r_result == ST_OK) && (r_op == OP_WDR);

  // Clear has priority, then the committed amount is added on top.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        r_withdrawn <= '0;
    else if (day_clear && w_wdr_commit) r_withdrawn <= r_amount;
    else if (day_clear)                r_withdrawn <= '0;
    else if (w_wdr_commit)             r_withdrawn <= r_withdrawn + r_amount;
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign gnt         = r_gnt;
  assign done        = r_done;
  assign status      = r_status;
  assign balance_out = r_balance_out;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_atm_account_arbiter.sv
// -----------------------------------------------------------------------------
// tb_atm_account_arbiter
// Directed bench for atm_account_arbiter (N_REQ=4, BAL_W=32). Expected
// completions are pushed to a scoreboard queue when a request is driven and
// popped when done pulses. Define ATM_DAILY_LIMIT_EN to also cover the
// daily-limit build.
// -----------------------------------------------------------------------------
module tb_atm_account_arbiter;

  localparam logic [1:0] OP_INQ = 2'b00;
  localparam logic [1:0] OP_DEP = 2'b01;
  localparam logic [1:0] OP_WDR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;
  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_INSUF = 2'b01;
  localparam logic [1:0] ST_LIMIT = 2'b10;
  localparam logic [1:0] ST_ERR   = 2'b11;
  localparam logic [31:0] INIT_BAL = 32'd1000000;

  typedef struct {
    int          id;
    logic [1:0]  st;
    logic [31:0] bal;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         day_clear;
  logic [3:0]   req;
  logic [7:0]   op;
  logic [127:0] amount;
  logic [3:0]   gnt;
  logic [3:0]   done;
  logic [1:0]   status;
  logic [31:0]  balance_out;
  logic         busy;

  logic [1:0]   op_t  [4];
  logic [31:0]  amt_t [4];

  exp_t         sb [$];
  logic [31:0]  model_bal;
  logic [31:0]  model_wd;
  int           total = 0;
  int           bad   = 0;

  assign op     = {op_t[3], op_t[2], op_t[1], op_t[0]};
  assign amount = {amt_t[3], amt_t[2], amt_t[1], amt_t[0]};

  always #5 clk = ~clk;

  atm_account_arbiter dut (
    .clk         (clk),
    .reset       (reset),
`ifdef ATM_DAILY_LIMIT_EN
    .day_clear   (day_clear),
`endif
    .req         (req),
    .op          (op),
    .amount      (amount),
    .gnt         (gnt),
    .done        (done),
    .status      (status),
    .balance_out (balance_out),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one transaction on the modelled account.
  function automatic void model_step(input logic [1:0] o, input logic [31:0] a,
                                     output logic [1:0] st, output logic [31:0] bal);
    logic [32:0] sum;
    st = ST_OK;
    case (o)
      OP_INQ: st = ST_OK;
      OP_DEP: begin
        sum = {1'b0, model_bal} + {1'b0, a};
        if (sum[32]) st = ST_ERR;
        else model_bal = sum[31:0];
      end
      OP_WDR: begin
        if (a > 32'd20000) st = ST_LIMIT;
`ifdef ATM_DAILY_LIMIT_EN
        else if (({1'b0, model_wd} + {1'b0, a}) > 33'd50000) st = ST_LIMIT;
`endif
        else if (a > model_bal) st = ST_INSUF;
        else begin
          model_bal = model_bal - a;
          model_wd  = model_wd + a;
        end
      end
      default: st = ST_ERR;
    endcase
    bal = model_bal;
  endfunction

  // Called at a negedge where done is high: pop and compare one completion.
  task automatic check_done();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_underflow observed=done=%0h expected=no completion", done);
    end else begin
      e = sb.pop_front();
      check("done_onehot", 32'(done), 32'(1) << e.id);
      check("gnt_in_resp", 32'(gnt), 32'(1) << e.id);
      check("status", 32'(status), 32'(e.st));
      check("balance_out", balance_out, e.bal);
    end
  endtask

  task automatic run_txn(input int id, input logic [1:0] o, input logic [31:0] a);
    exp_t e;
    int   cyc;
    op_t[id]  = o;
    amt_t[id] = a;
    req[id]   = 1'b1;
    e.id = id;
    model_step(o, a, e.st, e.bal);
    sb.push_back(e);
    cyc = 0;
    while (done == '0 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, 3);
    check_done();
    req[id] = 1'b0;
    @(negedge clk);
    check("done_single", 32'(done), 0);
    check("busy_idle", 32'(busy), 0);
  endtask

  task automatic pulse_day_clear();
    day_clear = 1'b1;
    @(negedge clk);
    day_clear = 1'b0;
    model_wd  = '0;
  endtask

  initial begin
    int   ngrant;
    int   ndone;
    int   cyc;
    int   last_cyc;
    logic [3:0] prev_gnt;

    reset     = 1'b0;
    day_clear = 1'b0;
    req       = '0;
    for (int i = 0; i < 4; i++) begin
      op_t[i]  = OP_INQ;
      amt_t[i] = '0;
    end
    model_bal = INIT_BAL;
    model_wd  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_status", 32'(status), 0);
    check("rst_balance_out", balance_out, 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    // Inquiry from terminal 0
    run_txn(0, OP_INQ, 32'd0);

    // Withdraw within limit, then above the per-transaction limit
    run_txn(1, OP_WDR, 32'd15000);
    run_txn(2, OP_WDR, 32'd25000);

    // Drain to 100: 49 x 20000 then 4900
    for (int i = 0; i < 49; i++) begin
`ifdef ATM_DAILY_LIMIT_EN
      pulse_day_clear();
`endif
      run_txn(i % 4, OP_WDR, 32'd20000);
    end
`ifdef ATM_DAILY_LIMIT_EN
    pulse_day_clear();
`endif
    run_txn(1, OP_WDR, 32'd4900);
    check("balance_100", balance_out, 32'd100);
    run_txn(2, OP_WDR, 32'd100);   // exact balance -> OK, balance 0
    run_txn(0, OP_WDR, 32'd1);     // insufficient

    // Refill, overflow deposit, reserved opcode (last on terminal 3 so rr_ptr=0)
    run_txn(0, OP_DEP, 32'd1000000);
    run_txn(2, OP_DEP, 32'hFFFF_FFFF);
    run_txn(3, OP_RSV, 32'd7);

    // Fairness: all four hold inquiries
    for (int k = 0; k < 5; k++) begin
      exp_t e;
      e.id  = k % 4;
      e.st  = ST_OK;
      e.bal = model_bal;
      sb.push_back(e);
    end
    for (int i = 0; i < 4; i++) op_t[i] = OP_INQ;
    req      = 4'hF;
    prev_gnt = '0;
    ngrant   = 0;
    ndone    = 0;
    cyc      = 0;
    last_cyc = 0;
    while (ndone < 5 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0 && gnt != prev_gnt) begin
        check("rr_order", 32'(gnt), 32'(1) << (ngrant % 4));
        if (ngrant > 0) check("rr_spacing", cyc - last_cyc, 4);
        last_cyc = cyc;
        ngrant++;
      end
      prev_gnt = gnt;
      if (done != '0) begin
        check("rr_one_done", $countones(done), 1);
        check_done();
        ndone++;
        if (ndone == 5) req = '0;
      end
    end
    check("rr_done_count", ndone, 5);
    @(negedge clk);
    check("rr_busy_after", 32'(busy), 0);

    // Reset during UPDATE of a 5000 withdraw
    op_t[1]  = OP_WDR;
    amt_t[1] = 32'd5000;
    req[1]   = 1'b1;
    @(negedge clk);                       // CHECK
    check("mid_gnt", 32'(gnt), 32'b0010);
    @(negedge clk);                       // UPDATE
    check("mid_busy", 32'(busy), 1);
    check("mid_done", 32'(done), 0);
    reset = 1'b0;
    req   = '0;
    #1;
    check("arst_gnt", 32'(gnt), 0);
    check("arst_done", 32'(done), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_balance_out", balance_out, 0);
    @(negedge clk);
    check("arst_no_done", 32'(done), 0);
    reset     = 1'b1;
    model_bal = INIT_BAL;
    model_wd  = '0;
    @(negedge clk);
    run_txn(0, OP_INQ, 32'd0);

`ifdef ATM_DAILY_LIMIT_EN
    // Daily cumulative limit
    run_txn(0, OP_WDR, 32'd20000);
    run_txn(1, OP_WDR, 32'd20000);
    run_txn(2, OP_WDR, 32'd20000);
    pulse_day_clear();
    run_txn(3, OP_WDR, 32'd20000);
`endif

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atm_account_arbiter.md
Name: atm_account_arbiter

Overview:
- Shares one account-balance register between N_REQ ATM front-end controllers (terminals).
- Uses round-robin arbitration and runs each transaction atomically: latch, check, update, respond.
- Sits between the per-terminal session FSMs and the balance storage, replacing per-terminal balance logic.
- Enforces the insufficient-funds rule, the per-transaction withdraw limit and the overflow rule in one place.

Parameters:
- N_REQ, 4: number of requesting terminals, 2..8.
- BAL_W, 32: balance and amount width in bits.
- INIT_BALANCE, 32'h000F4240: balance loaded on reset (1,000,000).
- MAX_WITHDRAW, 32'd20000: largest single withdrawal allowed.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-terminal request; held high until that terminal's done.
- op  in  2*N_REQ  per-terminal opcode. 00 = inquiry, 01 = deposit, 10 = withdraw, 11 = reserved.
- amount  in  BAL_W*N_REQ  per-terminal amount; ignored for inquiry.
- gnt  out  N_REQ  one-hot grant; high from CHECK through RESP.
- done  out  N_REQ  one-cycle completion pulse to the granted terminal.
- status  out  2  result, valid while any done bit is high. 00 = OK, 01 = INSUFFICIENT, 10 = LIMIT, 11 = BAD_OP/OVERFLOW.
- balance_out  out  BAL_W  balance after the transaction, valid with done.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: asynchronous on reset low.
  - State goes to IDLE and balance to INIT_BALANCE.
  - rr_ptr goes to 0.
  - gnt, done, status, busy and balance_out all go to 0.
  - A transaction in flight when reset asserts is dropped with no done pulse.
- FSM states: IDLE, CHECK, UPDATE, RESP.
- IDLE:
  - If any req bit is high, pick the winner by round-robin: the first asserted index at or after rr_ptr, wrapping modulo N_REQ.
  - On the same edge, latch winner id, op and amount, set the gnt bit, and go to CHECK.
  - With no request, stay in IDLE.
- CHECK: compute the result from the latched values and go to UPDATE.
  - Inquiry: OK.
  - Deposit: OK if balance+amount fits in BAL_W (use a BAL_W+1 carry check); otherwise OVERFLOW.
  - Withdraw, tested in this order: LIMIT if amount > MAX_WITHDRAW; INSUFFICIENT if amount > balance; otherwise OK. amount == balance is OK and leaves balance 0.
  - op 11: BAD_OP.
- UPDATE: go to RESP. The balance is written only when status is OK.
  - Deposit adds amount; withdraw subtracts amount.
  - Inquiry and any error leave the balance unchanged.
- RESP:
  - done[id] is high for exactly one cycle; status and balance_out are registered and valid.
  - gnt is cleared on the exit edge.
  - rr_ptr becomes (id+1) mod N_REQ.
  - Go to IDLE.
- Latency: req sampled high at edge 0 in IDLE gives done high between edges 2 and 3. Minimum spacing between grants is 4 cycles.
- Handshake rules:
  - Inputs are sampled only at the grant edge. Later changes to op or amount, or dropping req after the grant, do not affect a transaction already in flight; it completes.
  - A req that drops before it is granted is never serviced.
  - A terminal that keeps req high after its done is re-arbitrated as a new transaction. Because rr_ptr has advanced past it, other waiting terminals are served first.
- Fairness: with all N_REQ terminals requesting continuously, each is granted once every N_REQ transactions.
- Timing: balance_out and status hold their last values between transactions. done and gnt are never high outside RESP and CHECK..RESP respectively.

Optional Feature:
- Macro ATM_DAILY_LIMIT_EN.
- Defined:
  - Adds parameter DAILY_LIMIT (default 32'd50000) and input day_clear (1 bit, synchronous).
  - Adds a BAL_W-bit withdrawn_today accumulator, reset to 0 and cleared by day_clear.
  - In CHECK, a withdraw that passes the MAX_WITHDRAW test gets LIMIT if withdrawn_today+amount > DAILY_LIMIT. This test runs before the INSUFFICIENT test.
  - A successful withdraw adds amount to withdrawn_today in UPDATE.
  - If day_clear and an update occur in the same cycle, the accumulator becomes amount (clear first, then add).
- Undefined: no port, no parameter, no accumulator; behaviour is exactly as above.

Decomposition:
- Package atm_pkg holds:
  - the opcode localparams (OP_INQ, OP_DEP, OP_WDR, OP_RSV);
  - the status codes (ST_OK, ST_INSUF, ST_LIMIT, ST_ERR);
  - the FSM state encoding.
- One sub-module, rr_arbiter: req vector and rr_ptr in, one-hot grant and encoded id out, purely combinational. The top level holds the FSM, the balance register and the checks.

Test Plan:
- Reset, then terminal 0 inquiry → after 3 cycles done[0] pulses once, status=00, balance_out=1000000, busy low the following cycle.
- Terminal 1 withdraws 15000, then terminal 2 withdraws 25000 → first: status=00, balance_out=985000. Second: status=10 (LIMIT), balance stays 985000.
- Force the balance to 100 via a deposit/withdraw sequence, then withdraw 100 → status=00, balance 0. A further withdraw of 1 → status=01, balance 0.
- All 4 terminals hold req with inquiries → grants go 0,1,2,3,0 with a 4-cycle spacing, and exactly one done bit per RESP.
- Deposit 32'hFFFFFFFF on balance 1000000 → status=11, balance unchanged. op=11 → status=11.
- Assert reset during UPDATE of a withdraw of 5000 → no done pulse, balance=1000000, gnt=0. With ATM_DAILY_LIMIT_EN: withdrawals of 20000, 20000 and 20000 give OK, OK, LIMIT; after day_clear, a further 20000 gives OK.
